// File: rtl/clock_ratio_detector_if.sv
// Signal bundle between a divided-clock source and the ratio detector.
// The detector sits on the slave side: it samples clk_div and reports the
// measured half-period, lock status and event pulses back to the master.
// state_dbg mirrors the detector FSM so checkers can observe it directly.
`timescale 1ns/1ps
interface clock_ratio_detector_if #(
    parameter int CNT_W = 16
);
    logic             clk_div;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             locked;
    logic             lock_lost;
    logic             timeout;
    logic [1:0]       state_dbg;

    modport master (
        output clk_div,
        input  half_period, period, meas_valid, locked, lock_lost, timeout,
        input  state_dbg
    );

    modport slave (
        input  clk_div,
        output half_period, period, meas_valid, locked, lock_lost, timeout,
        output state_dbg
    );
endinterface

// File: rtl/clock_ratio_detector.sv
// Measures the clk-cycle count between consecutive clk_div transitions
// (either polarity) and declares lock after MATCH_COUNT identical
// measurements. Lock drops with a lock_lost pulse on a ratio change or a
// stall longer than TIMEOUT cycles.
//
// Event semantics: meas_valid, lock_lost and timeout are registered
// single-cycle pulses; half_period/period change only in the cycle meas_valid
// is high and otherwise hold their last value.
`timescale 1ns/1ps
module clock_ratio_detector #(
    parameter int CNT_W       = 16,
    parameter int MATCH_COUNT = 4,
    parameter int TIMEOUT     = 1000
) (
    input logic                   clk,
    input logic                   rst_n,
    clock_ratio_detector_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [7:0]       MATCH_TGT = 8'(MATCH_COUNT);
    localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_n;
    logic             s1, s2, s3;
    logic             edge_det;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [7:0]       match_cnt, match_n, match_upd;
    logic [CNT_W-1:0] half_q, half_n;
    logic [CNT_W:0]   period_q, period_n;
    logic             locked_q, locked_n;
    logic             mv_q, mv_n;
    logic             ll_q, ll_n;
    logic             to_q, to_n;

    // Three-flop chain: two for metastability, the third to detect a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.clk_div;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 ^ s3;
    // Saturate rather than wrap so a very slow source never reads as short.
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Next-state and next-output logic for the measurement FSM.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        match_n   = match_cnt;
        match_upd = 8'd1;
        half_n    = half_q;
        period_n  = period_q;
        locked_n  = locked_q;
        mv_n      = 1'b0;
        ll_n      = 1'b0;
        to_n      = 1'b0;
        case (state)
            IDLE: begin
                // First transition only arms the counter; no reference yet.
                if (edge_det) begin
                    cnt_n   = CNT_ONE;
                    state_n = MEASURE;
                end else begin
                    cnt_n = '0;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    cnt_n    = CNT_ONE;
                    half_n   = cnt;
                    period_n = {cnt, 1'b0};
                    mv_n     = 1'b1;
                    // match_cnt == 0 means the stored half_period is stale
                    // (pre-timeout), so it must not count as a match.
                    if (cnt == half_q && match_cnt != 8'd0) begin
                        match_upd = 8'(match_cnt + 8'd1);
                    end
                    match_n = match_upd;
                    if (match_upd >= MATCH_TGT) begin
                        state_n  = LOCKED;
                        locked_n = 1'b1;
                    end
                end else if (cnt == TO_VAL) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                    match_n = 8'd0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    cnt_n    = CNT_ONE;
                    half_n   = cnt;
                    period_n = {cnt, 1'b0};
                    mv_n     = 1'b1;
                    if (cnt != half_q) begin
                        locked_n = 1'b0;
                        ll_n     = 1'b1;
                        match_n  = 8'd1;
                        state_n  = MEASURE;
                    end
                end else if (cnt == TO_VAL) begin
                    to_n     = 1'b1;
                    ll_n     = 1'b1;
                    locked_n = 1'b0;
                    state_n  = IDLE;
                    cnt_n    = '0;
                    match_n  = 8'd0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n  = IDLE;
                cnt_n    = '0;
                match_n  = 8'd0;
                locked_n = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            match_cnt <= 8'd0;
            half_q    <= '0;
            period_q  <= '0;
            locked_q  <= 1'b0;
            mv_q      <= 1'b0;
            ll_q      <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            match_cnt <= match_n;
            half_q    <= half_n;
            period_q  <= period_n;
            locked_q  <= locked_n;
            mv_q      <= mv_n;
            ll_q      <= ll_n;
            to_q      <= to_n;
        end
    end

    assign bus.half_period = half_q;
    assign bus.period      = period_q;
    assign bus.meas_valid  = mv_q;
    assign bus.locked      = locked_q;
    assign bus.lock_lost   = ll_q;
    assign bus.timeout     = to_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Bench for clock_ratio_detector: directed clk_div patterns, expected
// measurements queued as stimulus is issued, popped by a negedge monitor.
`timescale 1ns/1ps
module tb_clock_ratio_detector;
    localparam int CNT_W       = 16;
    localparam int MATCH_COUNT = 4;
    localparam int TIMEOUT     = 20;
    localparam int W           = CNT_W + 2;   // {lock_lost, locked, half}

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    clock_ratio_detector_if #(.CNT_W(CNT_W)) bus ();

    clock_ratio_detector #(
        .CNT_W      (CNT_W),
        .MATCH_COUNT(MATCH_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] to_exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  range_mode = 1'b0;
    int  n_range = 0;
    int  cyc = 0;
    int  last_meas_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_meas(input int half, input bit lk, input bit ll);
        exp_q.push_back({ll, lk, CNT_W'(half)});
    endtask

    task automatic push_lock_seq(input int d);
        for (int i = 0; i < MATCH_COUNT - 1; i++) push_meas(d, 1'b0, 1'b0);
        push_meas(d, 1'b1, 1'b0);
    endtask

    task automatic toggle_every(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (d) @(posedge clk);
            #1;
            bus.clk_div = ~bus.clk_div;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n       = 1'b0;
        bus.clk_div = 1'b0;
        #1;
        check("rst_half_period", bus.half_period, 0);
        check("rst_period",      bus.period,      0);
        check("rst_meas_valid",  bus.meas_valid,  0);
        check("rst_locked",      bus.locked,      0);
        check("rst_lock_lost",   bus.lock_lost,   0);
        check("rst_timeout",     bus.timeout,     0);
        check("rst_state",       bus.state_dbg,   0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || to_exp_q.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("drain_meas_q",    exp_q.size(),    0);
        check("drain_timeout_q", to_exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n) begin
            cyc++;
            check("x_outputs", 32'($isunknown({bus.half_period, bus.period, bus.meas_valid,
                  bus.locked, bus.lock_lost, bus.timeout})), 0);
            if (bus.meas_valid) begin
                if (range_mode) begin
                    n_range++;
                    check("async_half_range", 32'(bus.half_period >= 6 && bus.half_period <= 7), 1);
                    check("async_period", bus.period, 2 * bus.half_period);
                    check("async_locked", bus.locked, 0);
                    check("async_lock_lost", bus.lock_lost, 0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_meas_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("half_period", bus.half_period, 32'(e[CNT_W-1:0]));
                    check("period",      bus.period,      2 * 32'(e[CNT_W-1:0]));
                    check("locked",      bus.locked,      32'(e[CNT_W]));
                    check("lock_lost",   bus.lock_lost,   32'(e[CNT_W+1]));
                end
                last_meas_cyc = cyc;
            end
            if (bus.timeout) begin
                if (to_exp_q.size() == 0) begin
                    check("unexpected_timeout", 1, 0);
                end else begin
                    e = to_exp_q.pop_front();
                    check("to_lock_lost",  bus.lock_lost,   32'(e[CNT_W+1]));
                    check("to_locked",     bus.locked,      0);
                    check("to_state_idle", bus.state_dbg,   0);
                    check("to_half_hold",  bus.half_period, 32'(e[CNT_W-1:0]));
                    check("to_gap",        cyc - last_meas_cyc, TIMEOUT);
                end
            end
            if (bus.lock_lost && !bus.meas_valid && !bus.timeout)
                check("stray_lock_lost", 1, 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.clk_div = 1'b0;
        do_reset();

        // D=3: arm edge, then 4 measurements, lock on the 4th.
        push_lock_seq(3);
        toggle_every(3, 1 + MATCH_COUNT);
        wait_drain();
        do_reset();

        // D=1: toggles every cycle, lock then hold for 100 measurements.
        push_lock_seq(1);
        for (int i = 0; i < 100; i++) push_meas(1, 1'b1, 1'b0);
        toggle_every(1, 1 + MATCH_COUNT + 100);
        wait_drain();
        do_reset();

        // Lock at D=5, switch to D=7: drop with lock_lost, relock after 3 more.
        push_lock_seq(5);
        push_meas(7, 1'b0, 1'b1);
        push_meas(7, 1'b0, 1'b0);
        push_meas(7, 1'b0, 1'b0);
        push_meas(7, 1'b1, 1'b0);
        toggle_every(5, 1 + MATCH_COUNT);
        toggle_every(7, 4);
        wait_drain();
        do_reset();

        // Lock at D=4, then stall: timeout with lock_lost, half_period holds.
        push_lock_seq(4);
        to_exp_q.push_back({1'b1, 1'b0, CNT_W'(4)});
        toggle_every(4, 1 + MATCH_COUNT);
        wait_drain();
        // Next toggle only re-arms; the one after measures from scratch.
        toggle_every(3, 1);
        push_meas(4, 1'b0, 1'b0);
        toggle_every(4, 1);
        wait_drain();
        do_reset();

        // Lock at D=3, async reset mid-lock, relock needs MATCH_COUNT+1 edges.
        push_lock_seq(3);
        toggle_every(3, 1 + MATCH_COUNT);
        wait_drain();
        do_reset();
        push_lock_seq(3);
        toggle_every(3, 1 + MATCH_COUNT);
        wait_drain();
        do_reset();

        // Edge landing exactly on cnt == TIMEOUT: measurement wins, locks.
        push_lock_seq(TIMEOUT);
        toggle_every(TIMEOUT, 1 + MATCH_COUNT);
        wait_drain();
        do_reset();

        // Asynchronous source, 65 ns half-period against 10 ns clk: 6/7 alternation.
        range_mode = 1'b1;
        n_range    = 0;
        #3;
        for (int i = 0; i < 40; i++) begin
            #65;
            bus.clk_div = ~bus.clk_div;
        end
        repeat (4) @(posedge clk);
        #1;
        check("async_meas_count", n_range, 39);
        do_reset();
        range_mode = 1'b0;

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
